uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one byte-level UART transmitter core between N_REQ independent message sources (score updates, game-state events, debug).
- Each source posts a single payload byte. The block buffers it, picks a source round-robin, and sends a 4-byte frame: SYNC, ID, DATA, CSUM.
- Sits between game logic and the UART TX core. Drives that core through a start/busy handshake.

Parameters:
- N_REQ, 2, number of requesters (1..16).
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req  in  N_REQ  per-source post strobe; 1-cycle pulse, level tolerated.
- req_data  in  8*N_REQ  payload for source i at bits [8i+7:8i].
- req_ack  out  N_REQ  1-cycle pulse when source i's byte is latched.
- overwrite  out  N_REQ  1-cycle pulse when a pending, unsent byte of source i is replaced.
- tx_start  out  1  1-cycle pulse: tx_data valid, core must begin sending.
- tx_data  out  8  byte to the UART core.
- tx_busy  in  1  core busy; must rise within 2 cycles of tx_start and fall when the stop bit ends.
- grant_id  out  4  index of the source whose frame is in flight.
- busy  out  1  high from frame grant until the CSUM byte completes.

Behaviour:
- Reset is async, all outputs 0. Also cleared: pending[] = 0, slot data = 0, rr_ptr = 0, FSM in IDLE.
- Pending slots, per i:
  - req[i] high: slot_data[i] <= req_data[i], pending[i] <= 1, req_ack[i] pulses next cycle.
  - If pending[i] was already 1 and not granted that same cycle, overwrite[i] pulses too.
  - Level req re-latches every cycle; ack pulses each cycle.
- Arbitration (IDLE only): if any pending bit is set, grant the first set index searching rr_ptr, rr_ptr+1, …, wrapping modulo N_REQ.
- On grant:
  - frame_data <= slot_data[g], grant_id <= g, pending[g] <= 0, rr_ptr <= (g+1) mod N_REQ, busy <= 1.
  - Same-cycle req[g] and grant: the frame uses the old slot_data. The new byte is latched and pending[g] stays 1. No overwrite pulse.
- FSM: IDLE -> START -> WAIT_HI -> WAIT_LO -> (next byte) START … -> IDLE.
  - byte_idx takes values 0..3, selecting SYNC_BYTE, {4'h0,grant_id}, frame_data, CSUM.
  - CSUM = SYNC_BYTE ^ {4'h0,grant_id} ^ frame_data.
- START:
  - Waits while tx_busy = 1.
  - When tx_busy = 0: tx_data <= selected byte, tx_start pulses for exactly 1 cycle, go to WAIT_HI.
  - tx_data holds until the next START.
- WAIT_HI:
  - Waits for tx_busy = 1.
  - If not seen within 2 cycles after tx_start, treat the byte as sent and proceed as from WAIT_LO. This is lost-handshake recovery; it must not hang.
- WAIT_LO: on tx_busy = 0, byte_idx++. If byte_idx was 3: busy <= 0 and go to IDLE; otherwise go to START.
- Latency:
  - Pending set to tx_start of SYNC is 2 cycles when idle and tx_busy = 0: latch cycle, then grant cycle, then START.
  - Back-to-back frames: IDLE re-arbitrates the cycle after CSUM completes.
- Boundaries:
  - rst mid-frame aborts immediately. tx_start drops; the core is expected to be reset by the same rst.
  - tx_busy held high indefinitely stalls in START/WAIT_LO. No timeout there.
  - N_REQ = 1: rr_ptr is constant 0.

Test Plan:
- Single post: req[0] with 8'h35, tx_busy model 20 cycles/byte -> tx_data sequence A5, 00, 35, 90; 4 tx_start pulses; req_ack[0] once; busy low after the 4th byte.
- Simultaneous: req[0]=11 and req[1]=22 in the same cycle -> frame for source 0 (A5,00,11,B4), then source 1 (A5,01,22,86); grant_id 0 then 1.
- Round-robin fairness: source 0 re-posts during its own frame while source 1 is pending -> source 1 served next, then source 0.
- Overwrite: req[1]=AA then req[1]=BB while a source-0 frame is active -> overwrite[1] pulses once; the source-1 frame carries BB.
- Lost handshake: tx_busy never rises after tx_start -> next tx_start 3 cycles later; the frame completes in 4 bytes.
- Reset mid-frame: assert rst during byte 2 -> outputs 0 immediately, pending cleared; after release, no tx_start until a new req.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that frames one posted byte per source as SYNC, ID, DATA, CSUM
// and feeds the frame byte-by-byte to a shared UART TX core over a start/busy handshake.
module uart_tx_arbiter #(
   parameter int         N_REQ     = 2,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ack,
   output logic [N_REQ-1:0]   overwrite,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic [3:0]         grant_id,
   output logic               busy
);

   // state   | meaning
   // IDLE    | no frame in flight, arbitrate among pending slots
   // START   | wait for core idle, then issue the current byte
   // WAIT_HI | wait for core to acknowledge with busy (2-cycle timeout)
   // WAIT_LO | wait for core to finish the byte
   typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

   state_t           state, state_nxt;
   logic [N_REQ-1:0] pending;
   logic [7:0]       slot_data [N_REQ];
   logic [3:0]       rr_ptr;
   logic [1:0]       byte_idx;
   logic [7:0]       frame_data;
   logic             hi_tmr;
   logic             any_pend;
   logic [3:0]       pick;
   logic [4:0]       idx;
   logic [7:0]       pick_data;
   logic [7:0]       byte_sel;
   logic             do_grant, do_issue, do_advance;

   // first pending index at or after rr_ptr, wrapping at N_REQ
   always_comb begin
      any_pend = 1'b0;
      pick     = 4'h0;
      idx      = 5'd0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = 5'(rr_ptr) + 5'(k);
         if (idx >= 5'(N_REQ)) idx = idx - 5'(N_REQ);
         for (int j = 0; j < N_REQ; j++) begin
            if (!any_pend && pending[j] && idx == 5'(j)) begin
               any_pend = 1'b1;
               pick     = 4'(j);
            end
         end
      end
   end

   always_comb begin
      pick_data = 8'h00;
      for (int j = 0; j < N_REQ; j++) begin
         if (pick == 4'(j)) pick_data = slot_data[j];
      end
   end

   always_comb begin
      case (byte_idx)
         2'd0:    byte_sel = SYNC_BYTE;
         2'd1:    byte_sel = {4'h0, grant_id};
         2'd2:    byte_sel = frame_data;
         default: byte_sel = SYNC_BYTE ^ {4'h0, grant_id} ^ frame_data;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      do_grant   = 1'b0;
      do_issue   = 1'b0;
      do_advance = 1'b0;
      case (state)
         IDLE: begin
            if (any_pend) begin
               do_grant  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (!tx_busy) begin
               do_issue  = 1'b1;
               state_nxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy) state_nxt = WAIT_LO;
            else if (hi_tmr == 1'b0) do_advance = 1'b1;
         end
         WAIT_LO: begin
            if (!tx_busy) do_advance = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (do_advance) state_nxt = (byte_idx == 2'd3) ? IDLE : START;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending    <= '0;
         req_ack    <= '0;
         overwrite  <= '0;
         rr_ptr     <= 4'h0;
         byte_idx   <= 2'd0;
         frame_data <= 8'h00;
         grant_id   <= 4'h0;
         busy       <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         hi_tmr     <= 1'b0;
         for (int i = 0; i < N_REQ; i++) slot_data[i] <= 8'h00;
      end else begin
         req_ack  <= req;
         tx_start <= do_issue;
         // a new post wins over the grant clear, so a same-cycle re-post stays pending
         for (int i = 0; i < N_REQ; i++) begin
            overwrite[i] <= req[i] && pending[i] && !(do_grant && pick == 4'(i));
            if (do_grant && pick == 4'(i)) pending[i] <= 1'b0;
            if (req[i]) begin
               pending[i]   <= 1'b1;
               slot_data[i] <= req_data[8*i +: 8];
            end
         end
         if (do_grant) begin
            frame_data <= pick_data;
            grant_id   <= pick;
            rr_ptr     <= (pick == 4'(N_REQ-1)) ? 4'h0 : pick + 4'h1;
            busy       <= 1'b1;
            byte_idx   <= 2'd0;
         end
         if (do_issue) begin
            tx_data <= byte_sel;
            hi_tmr  <= 1'b1;
         end else if (state == WAIT_HI && hi_tmr != 1'b0) begin
            hi_tmr <= hi_tmr - 1'b1;
         end
         if (do_advance) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) busy <= 1'b0;
         end
      end
   end

endmodule
